// File: rtl/seq_mul_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
package seq_mul_pkg;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must be able to hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Full-precision product width for two width-bit operands.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/CLA_Adder.sv
// Combinational carry-lookahead adder: generate/propagate terms per bit,
// carry chain resolved from those terms, sum = propagate ^ carry-in of bit.
module CLA_Adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic                  i_carry,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_carry
);

  logic [DATA_WIDTH-1:0] gen;
  logic [DATA_WIDTH-1:0] prop;

  assign gen  = i_data_a & i_data_b;
  assign prop = i_data_a ^ i_data_b;

  // Walk the generate/propagate terms to form each bit's carry and the sum.
  always_comb begin : carry_chain
    logic c;
    o_data  = '0;
    o_carry = 1'b0;
    c       = i_carry;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      o_data[i] = prop[i] ^ c;
      c         = gen[i] | (prop[i] & c);
    end
    o_carry = c;
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Unsigned shift-and-add multiplier, one partial-product add per cycle.
// Optional build macro: SEQ_MUL_ZERO_SKIP_EN -- a zero operand jumps straight
// to DONE with a zero product instead of running all DATA_WIDTH steps.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source keeps valid and data steady until that edge, and the
// sink may raise or drop ready at will. Operands are taken only in IDLE, the
// product is held in DONE until i_ready.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data_one,
  input  logic [DATA_WIDTH-1:0]   i_data_two,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_product,
  output logic                    o_busy,
  output state_e                  o_state
);

  localparam int PW = prod_width(DATA_WIDTH);
  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  state_e                state;
  logic [DATA_WIDTH-1:0] mcand;
  logic [PW-1:0]         prod_reg;
  logic [CW-1:0]         counter;
  logic                  ready_q;
  logic                  valid_q;
  logic                  busy_q;
  logic [PW-1:0]         product_q;

  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic [PW-1:0]         step_val;
  logic                  zero_op;

  // Multiplier bit 0 decides whether this step adds the multiplicand.
  assign addend = prod_reg[0] ? mcand : '0;

  CLA_Adder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_adder (
    .i_data_a (prod_reg[PW-1:DATA_WIDTH]),
    .i_data_b (addend),
    .i_carry  (1'b0),
    .o_data   (sum),
    .o_carry  (carry)
  );

  // Carry lands in the MSB after the right shift, so nothing is ever lost.
  assign step_val = {carry, sum, prod_reg[DATA_WIDTH-1:1]};

`ifdef SEQ_MUL_ZERO_SKIP_EN
  assign zero_op = (i_data_one == '0) || (i_data_two == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      prod_reg  <= '0;
      counter   <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mcand   <= i_data_one;
            counter <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (zero_op) begin
              prod_reg  <= '0;
              product_q <= '0;
              valid_q   <= 1'b1;
              state     <= DONE;
            end else begin
              prod_reg <= {{DATA_WIDTH{1'b0}}, i_data_two};
              state    <= CALC;
            end
          end
        end
        CALC: begin
          prod_reg <= step_val;
          counter  <= counter + CW'(1);
          if (counter == LAST_STEP) begin
            product_q <= step_val;
            valid_q   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_ready   = ready_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_product = product_q;
  assign o_state   = state;

endmodule

// File: doc/seq_mul_unit.md
# seq_mul_unit

Unsigned shift-and-add multiplier built around the team's combinational CLA adder. It takes two DATA_WIDTH-bit operands over a valid/ready handshake and runs one partial-product addition per cycle through the adder. It returns a 2*DATA_WIDTH-bit product over a second valid/ready handshake. It sits directly downstream of operand sources and feeds/consumes the adder stage every cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, operand width in bits; must be ≥ 2

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  operand pair is valid
- o_ready  output  1  block can accept an operand pair
- i_data_one  input  DATA_WIDTH  multiplicand
- i_data_two  input  DATA_WIDTH  multiplier
- o_valid  output  1  o_product is valid
- i_ready  input  1  downstream accepts o_product
- o_product  output  2*DATA_WIDTH  unsigned product
- o_busy  output  1  high in CALC and DONE

## Operation
- State machine has three states: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready, latch the multiplicand into mcand and the multiplier into the low half of prod_reg.
  - Clear the high half of prod_reg and the counter, then go to CALC.
- CALC, one step per cycle:
  - addend = prod_reg[0] ? mcand : 0.
  - {c, s} = adder(prod_reg[2W-1:W], addend), where c is the adder carry-out.
  - prod_reg <= {c, s, prod_reg[W-1:1]} (right shift by 1).
  - counter increments each step.
  - After exactly DATA_WIDTH steps, go to DONE.
- DONE:
  - o_valid=1 and o_product=prod_reg.
  - Hold both until i_ready, then go to IDLE.
- Width rules:
  - The adder is DATA_WIDTH wide with carry-in 0.
  - The carry-out becomes bit 2W-1 after the shift, so no overflow is possible.
  - The product is exact modulo 2^(2W), i.e. it is always exact.
- The counter is $clog2(DATA_WIDTH+1) bits wide.
- Inputs are ignored while o_ready=0. Operand changes during CALC have no effect.
- i_ready outside DONE is ignored.

## Timing
- Reset values: o_ready=1, o_valid=0, o_busy=0, o_product=0, state=IDLE, prod_reg=0, mcand=0, counter=0.
- Latency:
  - Handshake accepted at edge N.
  - o_valid rises after edge N+DATA_WIDTH, so it is high during cycle N+DATA_WIDTH+1.
- Throughput: one result per DATA_WIDTH+2 cycles when i_ready is held high.
- o_ready is low from the acceptance edge until the edge on which DONE exits. There is no overlap between result hand-off and the next acceptance.
- o_product is registered and stable while o_valid=1 and i_ready=0, for any number of stall cycles.
- Asserting i_rst_n low in any state immediately forces all reset values. Any in-flight operation is discarded and no partial result is ever presented.
- The first edge after reset release is a normal IDLE cycle.

## Configuration
- Macro: SEQ_MUL_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if an accepted pair has i_data_one==0 or i_data_two==0, go straight to DONE with prod_reg=0.
  - o_valid rises after the acceptance edge, giving a latency of 1 cycle.
- Undefined:
  - Zero operands take the full DATA_WIDTH-step path.
  - The result is still 0.
- The handshake rules are identical in both builds.

## Structure
- A shared package seq_mul_pkg holds:
  - the state enum state_e {IDLE, CALC, DONE}
  - the function for the counter width
  - the localparam PROD_WIDTH = 2*DATA_WIDTH, as a package function of width
- Sub-module: the existing CLA_Adder, one instance with DATA_WIDTH=DATA_WIDTH.
  - Its operands are the high half of prod_reg and the gated multiplicand.
  - Its o_data and o_carry feed the shift.
- The top level holds only the FSM, counter, registers and handshake logic.

## Test plan
All cases use DATA_WIDTH=8.
- 13 × 11 with i_ready=1 → o_product=143 (0x008F), o_valid exactly 1 cycle, rising 9 cycles after the acceptance edge.
- 255 × 255 → o_product=0xFE01. Checks the carry-out path into the MSB on every step.
- 200 × 3 with i_ready held low for 5 cycles in DONE → o_product=600 stable, o_valid held, o_ready=0 throughout. Then o_ready=1 on the cycle after i_ready.
- 0 × 77:
  - Without the macro → 0 after 9 cycles.
  - With SEQ_MUL_ZERO_SKIP_EN → 0 with o_valid on the cycle after acceptance.
- Reset pulse during CALC step 4 of 100 × 100 → all outputs reset immediately, no o_valid. A following 7 × 9 → 63.
- Back-to-back stream of 50 random pairs with random i_valid/i_ready → every product matches the reference model, in order, none dropped or duplicated.
